fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-003 SHALL have parameter STOP_BITS, default 1: number of stop bits, 1 or 2.
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port empty_i, input, 1: upstream sync_fifo empty flag.
REQ-007 SHALL have port data_i, input, 8: upstream sync_fifo read data.
REQ-008 SHALL have port rd_en_o, output, 1: read strobe to the sync_fifo rd_en_i input.
REQ-009 SHALL have port tx_o, output, 1: serial line, idle high.
REQ-010 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-011 SHALL have port done_o, output, 1: one-cycle pulse at frame end.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-013 IDLE with empty_i=0 SHALL drive rd_en_o=1 for exactly one cycle and go to FETCH.
REQ-014 IDLE with empty_i=1 SHALL hold rd_en_o=0 and tx_o=1.
REQ-015 rd_en_o SHALL never be asserted outside IDLE; at most one read per frame, never while empty_i=1.
REQ-016 FETCH SHALL last one cycle, latch data_i into an 8-bit shift register, clear the bit counter, and go to START.
REQ-017 data_i is sampled in the cycle after rd_en_o (registered FIFO read).
REQ-018 START SHALL drive tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit counter SHALL select the bit and wrap 7->0 on exit.
REQ-020 After bit 7, DATA SHALL go to PARITY if PARITY!=0, else to STOP.
REQ-021 PARITY SHALL drive the XOR of the 8 data bits for even, and its inverse for odd, for CLKS_PER_BIT cycles.
REQ-022 STOP SHALL drive tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-023 On the last STOP cycle, done_o SHALL be 1 for one cycle and the FSM SHALL go to IDLE.
REQ-024 Back-to-back frames SHALL be separated by exactly 2 idle-high cycles (IDLE + FETCH).
REQ-025 The baud counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, and reload to 0 on every bit boundary and state entry.
REQ-026 tx_o SHALL be driven from a register, with no combinational glitches.
REQ-027 empty_i changes during START/DATA/PARITY/STOP SHALL be ignored.

Reset
REQ-028 With rst=0 at a rising edge, the next state SHALL be IDLE, tx_o=1, rd_en_o=0, busy_o=0, and done_o=0.
REQ-029 Reset SHALL also clear the shift register, the bit counter and the baud counter to 0.
REQ-030 Reset mid-frame SHALL abort the frame immediately, with tx_o=1 in the first cycle after the reset edge and no done_o.
REQ-031 The aborted byte SHALL be lost and not re-read.
REQ-032 The first read after rst deasserts SHALL occur no earlier than the first IDLE cycle with rst=1 and empty_i=0.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-033 Reset test: hold rst=0 for 3 cycles, then release with empty_i=1 -> tx_o=1, rd_en_o=0, busy_o=0 for 20 cycles.
REQ-034 Single byte, PARITY=0, data_i=0xA5 -> exactly one rd_en_o pulse; tx_o sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; done_o 40 cycles after FETCH.
REQ-035 Parity test, byte 0x07: PARITY=1 -> parity bit 1; PARITY=2 -> parity bit 0; each frame 11 bits = 44 cycles.
REQ-036 Drain test: sync_fifo preloaded with 0..7 -> 8 rd_en_o pulses, frames in order 0..7, 2-cycle gaps, empty_i=1 after the 8th read, no 9th rd_en_o.
REQ-037 Abort test: rst=0 during DATA bit 3 of 0xFF -> tx_o=1 next cycle, no done_o; after release with empty_i=0, the next byte is fetched normally.
REQ-038 Stop-bit test: STOP_BITS=2 -> stop high for 8 cycles before done_o; the next start bit comes no earlier than 2 cycles later.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a registered-read sync_fifo and serialises them
// as start / 8 data bits LSB first / optional parity / 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty_i,
    input  logic [7:0] data_i,
    output logic       rd_en_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BaudPre  = 16'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e      state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] baud_q;
    logic        parity_q;
    logic        tx_q;
    logic        done_q;
    logic        parity_bit;
    logic        last_stop;
    logic        baud_wrap;

    assign parity_bit = (PARITY == 2) ? ~parity_q : parity_q;
    // bit_cnt_q[0] counts stop bits; it is 0 on STOP entry because DATA wraps it 7->0.
    assign last_stop  = (STOP_BITS < 2) || bit_cnt_q[0];
    assign baud_wrap  = (baud_q == BaudLast);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                    if (!empty_i) begin
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    shift_q   <= data_i;
                    parity_q  <= ^data_i;
                    bit_cnt_q <= '0;
                    baud_q    <= '0;
                    tx_q      <= 1'b0;
                    state_q   <= StStart;
                end
                StStart: begin
                    if (baud_wrap) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StData: begin
                    if (baud_wrap) begin
                        baud_q    <= '0;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            if (PARITY != 0) begin
                                tx_q    <= parity_bit;
                                state_q <= StParity;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StParity: begin
                    if (baud_wrap) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StStop: begin
                    tx_q <= 1'b1;
                    // Registered done_o is set one cycle early so it lands on the last stop cycle.
                    if (baud_q == BaudPre && last_stop) begin
                        done_q <= 1'b1;
                    end
                    if (baud_wrap) begin
                        baud_q <= '0;
                        if (last_stop) begin
                            bit_cnt_q <= '0;
                            state_q   <= StIdle;
                        end else begin
                            bit_cnt_q <= 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Read strobe is decoded in the IDLE cycle itself so the registered FIFO presents
    // the byte during FETCH; gated by rst so no read is issued while reset is held.
    assign rd_en_o = rst && (state_q == StIdle) && !empty_i;
    assign tx_o    = tx_q;
    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: four instances (no parity, even, odd, two stop bits)
// each fed by a small registered-read FIFO model.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] empty;
    logic [3:0] rd_en;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] done;
    logic [7:0] data [4];

    logic [7:0] fmem [4][64];
    int         fcnt [4];
    int         frd  [4];
    int         rd_bad = 0;
    int         tests  = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_p0 (
        .clk(clk), .rst(rst), .empty_i(empty[0]), .data_i(data[0]),
        .rd_en_o(rd_en[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .empty_i(empty[1]), .data_i(data[1]),
        .rd_en_o(rd_en[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .empty_i(empty[2]), .data_i(data[2]),
        .rd_en_o(rd_en[2]), .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst(rst), .empty_i(empty[3]), .data_i(data[3]),
        .rd_en_o(rd_en[3]), .tx_o(tx[3]), .busy_o(busy[3]), .done_o(done[3]));

    // FIFO model: data appears on the cycle after the read strobe.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i] = (frd[i] == fcnt[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd_en[i] === 1'b1) begin
                if (empty[i]) begin
                    rd_bad <= rd_bad + 1;
                end else begin
                    data[i] <= fmem[i][frd[i]];
                    frd[i]  <= frd[i] + 1;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            fcnt[i] = 0;
            frd[i]  = 0;
            data[i] = 8'h00;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input int i, input logic [7:0] d);
        fmem[i][fcnt[i]] = d;
        fcnt[i] = fcnt[i] + 1;
    endtask

    task automatic wait_rd(input int i, output bit found, output int waited);
        found  = 1'b0;
        waited = 0;
        #1;
        for (int n = 0; n < 16; n++) begin
            if (rd_en[i] === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
            #1;
            waited++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if (tx !== 4'hF || rd_en !== 4'h0 || busy !== 4'h0 || done !== 4'h0) begin
                fails++;
                $display("FAIL reset_hold c=%0d tx=%b rd_en=%b busy=%b done=%b want tx=1111 rest 0",
                         c, tx, rd_en, busy, done);
            end
        end
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            tests++;
            if (tx !== 4'hF || rd_en !== 4'h0 || busy !== 4'h0) begin
                fails++;
                $display("FAIL reset_idle c=%0d tx=%b rd_en=%b busy=%b want 1111/0000/0000",
                         c, tx, rd_en, busy);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] exp;
        bit         found;
        int         waited;
        exp = {1'b1, 8'hA5, 1'b0};
        push(0, 8'hA5);
        wait_rd(0, found, waited);
        tests++;
        if (!found || waited != 0) begin
            fails++;
            $display("FAIL single_rd found=%0d waited=%0d want 1/0", found, waited);
        end
        step();
        tests++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b1 || rd_en[0] !== 1'b0) begin
            fails++;
            $display("FAIL single_fetch tx=%b busy=%b rd_en=%b want 1/1/0", tx[0], busy[0], rd_en[0]);
        end
        for (int k = 0; k < 40; k++) begin
            step();
            tests++;
            if (tx[0] !== exp[k/4] || done[0] !== (k == 39) || rd_en[0] !== 1'b0) begin
                fails++;
                $display("FAIL single_bit k=%0d tx=%b done=%b rd_en=%b want tx=%b done=%b rd_en=0",
                         k, tx[0], done[0], rd_en[0], exp[k/4], (k == 39));
            end
        end
        step();
        tests++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || tx[0] !== 1'b1) begin
            fails++;
            $display("FAIL single_end busy=%b done=%b tx=%b want 0/0/1", busy[0], done[0], tx[0]);
        end
    endtask

    task automatic test_parity();
        logic [10:0] exp;
        logic        par;
        bit          found;
        int          waited;
        for (int p = 1; p <= 2; p++) begin
            par = (p == 1) ? 1'b1 : 1'b0;
            exp = {1'b1, par, 8'h07, 1'b0};
            push(p, 8'h07);
            wait_rd(p, found, waited);
            tests++;
            if (!found) begin
                fails++;
                $display("FAIL parity_rd p=%0d found=0 want 1", p);
            end
            step();
            for (int k = 0; k < 44; k++) begin
                step();
                tests++;
                if (tx[p] !== exp[k/4] || done[p] !== (k == 43)) begin
                    fails++;
                    $display("FAIL parity_bit p=%0d k=%0d tx=%b done=%b want tx=%b done=%b",
                             p, k, tx[p], done[p], exp[k/4], (k == 43));
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        bit         found;
        int         waited;
        int         bad;
        int         done_cnt;
        int         done_at;
        int         extra_rd;
        for (int f = 0; f < 8; f++) begin
            push(0, 8'(f));
        end
        for (int f = 0; f < 8; f++) begin
            exp = {1'b1, 8'(f), 1'b0};
            wait_rd(0, found, waited);
            tests++;
            if (!found || (f > 0 && waited != 0) || tx[0] !== 1'b1) begin
                fails++;
                $display("FAIL drain_gap f=%0d found=%0d waited=%0d tx=%b want 1/0/1",
                         f, found, waited, tx[0]);
            end
            step();
            tests++;
            if (empty[0] !== (f == 7) || tx[0] !== 1'b1) begin
                fails++;
                $display("FAIL drain_fetch f=%0d empty=%b tx=%b want empty=%b tx=1",
                         f, empty[0], tx[0], (f == 7));
            end
            bad      = 0;
            done_cnt = 0;
            done_at  = -1;
            for (int k = 0; k < 40; k++) begin
                step();
                if (tx[0] !== exp[k/4] || rd_en[0] !== 1'b0) bad++;
                if (done[0] === 1'b1) begin
                    done_cnt++;
                    done_at = k;
                end
            end
            tests++;
            if (bad != 0 || done_cnt != 1 || done_at != 39) begin
                fails++;
                $display("FAIL drain_frame f=%0d bad_cycles=%0d done_cnt=%0d done_at=%0d want 0/1/39",
                         f, bad, done_cnt, done_at);
            end
            step();
        end
        extra_rd = 0;
        for (int c = 0; c < 20; c++) begin
            if (rd_en[0] !== 1'b0 || busy[0] !== 1'b0) extra_rd++;
            step();
        end
        tests++;
        if (extra_rd != 0) begin
            fails++;
            $display("FAIL drain_ninth_read cycles=%0d want 0", extra_rd);
        end
    endtask

    task automatic test_abort();
        logic [9:0] exp;
        bit         found;
        int         waited;
        int         bad;
        exp = {1'b1, 8'h3C, 1'b0};
        push(0, 8'hFF);
        push(0, 8'h3C);
        wait_rd(0, found, waited);
        step();
        repeat (18) step();
        tests++;
        if (!found || busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL abort_setup found=%0d busy=%b want 1/1", found, busy[0]);
        end
        rst = 1'b0;
        step();
        tests++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0 || rd_en[0] !== 1'b0) begin
            fails++;
            $display("FAIL abort_edge tx=%b busy=%b done=%b rd_en=%b want 1/0/0/0",
                     tx[0], busy[0], done[0], rd_en[0]);
        end
        step();
        tests++;
        if (rd_en[0] !== 1'b0 || done[0] !== 1'b0) begin
            fails++;
            $display("FAIL abort_hold rd_en=%b done=%b want 0/0", rd_en[0], done[0]);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (rd_en[0] !== 1'b1) begin
            fails++;
            $display("FAIL abort_reread rd_en=%b want 1", rd_en[0]);
        end
        step();
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (tx[0] !== exp[k/4] || done[0] !== (k == 39)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL abort_next_frame bad_cycles=%0d want 0 (byte 3C)", bad);
        end
        step();
    endtask

    task automatic test_stop_bits();
        logic [10:0] exp;
        bit          found;
        int          waited;
        exp = {2'b11, 8'h55, 1'b0};
        push(3, 8'h55);
        push(3, 8'h80);
        wait_rd(3, found, waited);
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL stop2_rd found=0 want 1");
        end
        step();
        for (int k = 0; k < 44; k++) begin
            step();
            tests++;
            if (tx[3] !== exp[k/4] || done[3] !== (k == 43)) begin
                fails++;
                $display("FAIL stop2_bit k=%0d tx=%b done=%b want tx=%b done=%b",
                         k, tx[3], done[3], exp[k/4], (k == 43));
            end
        end
        step();
        tests++;
        if (tx[3] !== 1'b1 || rd_en[3] !== 1'b1) begin
            fails++;
            $display("FAIL stop2_idle tx=%b rd_en=%b want 1/1", tx[3], rd_en[3]);
        end
        step();
        tests++;
        if (tx[3] !== 1'b1) begin
            fails++;
            $display("FAIL stop2_fetch tx=%b want 1", tx[3]);
        end
        step();
        tests++;
        if (tx[3] !== 1'b0) begin
            fails++;
            $display("FAIL stop2_next_start tx=%b want 0", tx[3]);
        end
        repeat (50) step();
    endtask

    task automatic test_protocol();
        tests++;
        if (rd_bad != 0) begin
            fails++;
            $display("FAIL rd_while_empty count=%0d want 0", rd_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_parity();
        test_back_to_back();
        test_abort();
        test_stop_bits();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d want finish before 200000", tests);
        $fatal(1, "timeout");
    end

endmodule
